// File: rtl/fnd_pkg.sv
// Shared constants and BCD helper for the six-digit FND scan driver.
package fnd_pkg;
   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;
   localparam logic [5:0] COM_OFF  = 6'b111111;

   // Returns {tens, ones}; 60..63 yields 4'hF in both nibbles so the decoder shows dashes.
   function automatic logic [7:0] bcd_split(input logic [5:0] v);
      logic [5:0] t;
      logic [5:0] o;
      if (v >= 6'd60) return 8'hFF;
      t = v / 6'd10;
      o = v % 6'd10;
      return {t[3:0], o[3:0]};
   endfunction
endpackage

// File: rtl/seg_dec7.sv
// BCD digit to active-high gfedcba pattern; codes 10..15 render as a dash.
module seg_dec7
   import fnd_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/fnd_scan6.sv
// Six-digit multiplexed 7-segment driver: prescaled digit scan, frame-coherent
// shadow capture of sec/min/hour, BCD split and registered seg/dp/com.
module fnd_scan6
   import fnd_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [5:0] hour,
   input  logic       blank,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] com
);
   localparam logic [31:0] PRE_MAX = 32'(SCAN_DIV - 1);

   logic [31:0] pre;
   logic [2:0]  idx;
   logic        tick, wrap;
   logic [5:0]  sh_sec, sh_min, sh_hour;
   logic [5:0]  field;
   logic [7:0]  bcd;
   logic [3:0]  digit;
   logic [6:0]  seg_nx;
   logic [5:0]  com_nx;
   logic        dp_nx;

   assign tick = (pre == PRE_MAX);
   assign wrap = tick && (idx == 3'd5);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
         idx <= '0;
      end else begin
         pre <= tick ? '0 : pre + 32'd1;
         if (idx > 3'd5)
            idx <= '0;
         else if (tick)
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
   end

   // Shadows only move at the frame boundary so one frame never mixes old and new values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_sec  <= '0;
         sh_min  <= '0;
         sh_hour <= '0;
      end else if (wrap) begin
         sh_sec  <= sec;
         sh_min  <= min;
         sh_hour <= hour;
      end
   end

   always_comb begin
      field = sh_hour;
      case (idx[2:1])
         2'd0:    field = sh_sec;
         2'd1:    field = sh_min;
         default: field = sh_hour;
      endcase
   end

   assign bcd    = bcd_split(field);
   assign digit  = idx[0] ? bcd[7:4] : bcd[3:0];
   assign com_nx = ~(6'b000001 << idx);
   assign dp_nx  = (idx == 3'd2) || (idx == 3'd4);

   seg_dec7 u_dec (
      .bcd (digit),
      .seg (seg_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_OFF;
         dp  <= 1'b0;
         com <= COM_OFF;
      end else if (blank) begin
         seg <= SEG_OFF;
         dp  <= 1'b0;
         com <= COM_OFF;
      end else begin
         seg <= seg_nx;
         dp  <= dp_nx;
         com <= com_nx;
      end
   end
endmodule
